// File: rtl/sntc_ldpc_encoder_stream.sv
// Streaming systematic LDPC encoder: W-bit message words in,
// W-bit codeword words (message then parity) out.
module sntc_ldpc_encoder_stream #(
  parameter int KK = 40,
  parameter int MM = 168,
  parameter int NN = KK + MM,
  parameter int W = 8,
  parameter logic [KK*MM-1:0] PMAT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         frame_err
);

  localparam int NWI = KK / W;
  localparam int NWO = NN / W;
  localparam int CW = (NWO > 1) ? $clog2(NWO) : 1;
  localparam logic [CW-1:0] LAST_IN = CW'(NWI - 1);
  localparam logic [CW-1:0] LAST_OUT = CW'(NWO - 1);

  typedef enum logic {LOAD, EMIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          armed;
  logic [NN-1:0] cw;
  logic [MM-1:0] acc;
  logic [MM-1:0] acc_nxt;
  logic          take;
  logic          give;
  logic          at_last_in;

  assign in_ready   = armed && (state == LOAD);
  assign out_valid  = (state == EMIT);
  assign out_last   = out_valid && (cnt == LAST_OUT);
  assign out_data   = out_valid ? cw[int'(cnt)*W +: W] : '0;
  assign busy       = out_valid || (cnt != '0);
  assign take       = in_valid && in_ready;
  assign give       = out_valid && out_ready;
  assign at_last_in = (cnt == LAST_IN);

  // Fold every set bit of the incoming word into the parity
  always_comb begin
    acc_nxt = acc;
    for (int b = 0; b < W; b++) begin
      if (in_data[b] && (int'(cnt) * W + b) < KK)
        acc_nxt = acc_nxt ^ PMAT[(int'(cnt) * W + b) * MM +: MM];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= '0;
      armed     <= 1'b0;
      cw        <= '0;
      acc       <= '0;
      frame_err <= 1'b0;
    end else begin
      armed     <= 1'b1;
      frame_err <= 1'b0;
      if (clr) begin
        state <= LOAD;
        cnt   <= '0;
        cw    <= '0;
        acc   <= '0;
      end else if (state == LOAD) begin
        if (take) begin
          if (in_last && !at_last_in) begin
            frame_err <= 1'b1;
            cnt       <= '0;
            cw        <= '0;
            acc       <= '0;
          end else begin
            cw[int'(cnt)*W +: W] <= in_data;
            if (at_last_in) begin
              state      <= EMIT;
              cnt        <= '0;
              acc        <= '0;
              cw[NN-1:KK] <= acc_nxt;
              frame_err  <= !in_last;
            end else begin
              acc <= acc_nxt;
              cnt <= cnt + 1'b1;
            end
          end
        end
      end else if (give) begin
        if (cnt == LAST_OUT) begin
          state <= LOAD;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sntc_ldpc_encoder_stream.sv
// Bench for sntc_ldpc_encoder_stream: three codes (identity, all-ones,
// mixed) share one stimulus stream and are checked against a parity model.
module tb_sntc_ldpc_encoder_stream;

  localparam int K = 8;
  localparam int M = 8;
  localparam int W = 4;
  localparam logic [63:0] P0 = 64'h8040_2010_0804_0201;
  localparam logic [63:0] P1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] P2 = 64'h3C5A_96E1_0F7B_D249;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;

  logic [3:0] out_data [3];
  logic       out_valid [3];
  logic       out_last [3];
  logic       in_ready [3];
  logic       busy [3];
  logic       frame_err [3];

  int errors = 0;
  int checks = 0;
  int ferr_cnt [3] = '{0, 0, 0};

  logic [3:0] got [3][4];
  logic       gotlast [3][4];
  int         n_got [3];
  int         unstable;
  int         rdy_during;
  int         timed_out;
  int         ncyc;

  sntc_ldpc_encoder_stream #(.KK(K), .MM(M), .W(W), .PMAT(P0)) u0 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready[0]), .out_data(out_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_last(out_last[0]), .busy(busy[0]), .frame_err(frame_err[0]));

  sntc_ldpc_encoder_stream #(.KK(K), .MM(M), .W(W), .PMAT(P1)) u1 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready[1]), .out_data(out_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_last(out_last[1]), .busy(busy[1]), .frame_err(frame_err[1]));

  sntc_ldpc_encoder_stream #(.KK(K), .MM(M), .W(W), .PMAT(P2)) u2 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready[2]), .out_data(out_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready),
    .out_last(out_last[2]), .busy(busy[2]), .frame_err(frame_err[2]));

  always #5 clk = ~clk;

  always @(negedge clk)
    for (int d = 0; d < 3; d++)
      if (frame_err[d] === 1'b1) ferr_cnt[d]++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] pm(input int d);
    case (d)
      0: return P0;
      1: return P1;
      default: return P2;
    endcase
  endfunction

  // Expected codeword {parity, message} straight from the XOR definition
  function automatic logic [15:0] codeword(input int d, input logic [7:0] m);
    logic [63:0] p;
    logic [7:0] par;
    p = pm(d);
    par = '0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < K; j++)
        if (m[j] && p[j*M+i]) par[i] = ~par[i];
    return {par, m};
  endfunction

  task automatic send_word(input logic [3:0] d, input logic last);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_frame(input logic [7:0] m, input bit mark_last,
                            input bit gaps);
    for (int k = 0; k < 2; k++) begin
      if (gaps) repeat ($urandom % 3) begin @(posedge clk); #1; end
      send_word(m[k*4 +: 4], mark_last && k == 1);
    end
  endtask

  // mode 0: ready high, 1: ready 1010..., 2: random ready
  task automatic collect(input int mode);
    logic [3:0] hold [3];
    bit holding [3];
    bit done;
    for (int d = 0; d < 3; d++) begin
      n_got[d] = 0;
      holding[d] = 0;
      hold[d] = '0;
    end
    unstable = 0;
    rdy_during = 0;
    timed_out = 0;
    ncyc = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = (cyc % 2 == 0);
      else out_ready = 1'($urandom % 2);
      for (int d = 0; d < 3; d++) begin
        if (out_valid[d] === 1'b1) begin
          if (in_ready[d] !== 1'b0) rdy_during++;
          if (holding[d] && out_data[d] !== hold[d]) unstable++;
          if (out_ready) begin
            if (n_got[d] < 4) begin
              got[d][n_got[d]] = out_data[d];
              gotlast[d][n_got[d]] = out_last[d];
            end
            n_got[d]++;
            holding[d] = 0;
          end else begin
            holding[d] = 1;
            hold[d] = out_data[d];
          end
        end
      end
      @(posedge clk); #1;
      done = 1;
      for (int d = 0; d < 3; d++) if (n_got[d] < 4) done = 0;
      if (done) begin
        ncyc = cyc + 1;
        break;
      end
    end
    out_ready = 1'b1;
    for (int d = 0; d < 3; d++) if (n_got[d] != 4) timed_out = 1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1 rst = 1'b1;
    #20;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({in_ready[d], out_valid[d], out_last[d], out_data[d], busy[d],
           frame_err[d]} !== 9'b0) begin
        errors++;
        $display("FAIL reset_vals dut%0d got rdy=%b ov=%b ol=%b od=%h bz=%b fe=%b exp all 0",
                 d, in_ready[d], out_valid[d], out_last[d], out_data[d],
                 busy[d], frame_err[d]);
      end
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (in_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL rdy_on_release got %b exp 0", in_ready[0]);
    end
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (in_ready[d] !== 1'b1 || busy[d] !== 1'b0 || out_valid[d] !== 1'b0) begin
        errors++;
        $display("FAIL rdy_after_edge dut%0d got rdy=%b bz=%b ov=%b exp 1 0 0",
                 d, in_ready[d], busy[d], out_valid[d]);
      end
    end
  endtask

  task automatic test_identity;
    logic [7:0] m;
    int e0;
    m = 8'hA5;
    e0 = ferr_cnt[0];
    send_frame(m, 1, 0);
    checks++;
    if (busy[0] !== 1'b1 || out_valid[0] !== 1'b1 || out_data[0] !== 4'h5) begin
      errors++;
      $display("FAIL id_latency got bz=%b ov=%b od=%h exp 1 1 5",
               busy[0], out_valid[0], out_data[0]);
    end
    collect(0);
    checks++;
    if (timed_out != 0 || ncyc != 4) begin
      errors++;
      $display("FAIL id_cycles got %0d exp 4 (timeout=%0d)", ncyc, timed_out);
    end
    checks++;
    if ({got[0][3], got[0][2], got[0][1], got[0][0]} !== 16'hA5A5) begin
      errors++;
      $display("FAIL id_words got %h%h%h%h exp a5a5",
               got[0][3], got[0][2], got[0][1], got[0][0]);
    end
    for (int d = 0; d < 3; d++) begin
      logic [15:0] e;
      e = codeword(d, m);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got[d][k] !== e[k*4 +: 4]) begin
          errors++;
          $display("FAIL id_model dut%0d w%0d got %h exp %h",
                   d, k, got[d][k], e[k*4 +: 4]);
        end
      end
      checks++;
      if ({gotlast[d][3], gotlast[d][2], gotlast[d][1], gotlast[d][0]} !== 4'b1000) begin
        errors++;
        $display("FAIL id_last dut%0d got %b%b%b%b exp 1000", d,
                 gotlast[d][3], gotlast[d][2], gotlast[d][1], gotlast[d][0]);
      end
    end
    checks++;
    if (in_ready[0] !== 1'b1 || ferr_cnt[0] != e0) begin
      errors++;
      $display("FAIL id_after got rdy=%b ferr=%0d exp 1 0", in_ready[0],
               ferr_cnt[0] - e0);
    end
  endtask

  task automatic test_all_ones;
    logic [7:0] msgs [2];
    logic [15:0] exp1 [2];
    msgs = '{8'h07, 8'h03};
    exp1 = '{16'hFF07, 16'h0003};
    for (int t = 0; t < 2; t++) begin
      send_frame(msgs[t], 1, 0);
      collect(0);
      checks++;
      if ({got[1][3], got[1][2], got[1][1], got[1][0]} !== exp1[t]) begin
        errors++;
        $display("FAIL ones_words msg=%h got %h%h%h%h exp %h", msgs[t],
                 got[1][3], got[1][2], got[1][1], got[1][0], exp1[t]);
      end
      for (int d = 0; d < 3; d++) begin
        logic [15:0] e;
        e = codeword(d, msgs[t]);
        checks++;
        if ({got[d][3], got[d][2], got[d][1], got[d][0]} !== e) begin
          errors++;
          $display("FAIL ones_model dut%0d got %h%h%h%h exp %h", d,
                   got[d][3], got[d][2], got[d][1], got[d][0], e);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] m;
    m = 8'hA5;
    send_frame(m, 1, 0);
    collect(1);
    checks++;
    if (timed_out != 0 || unstable != 0 || rdy_during != 0) begin
      errors++;
      $display("FAIL bp_hold got timeout=%0d unstable=%0d rdy=%0d exp 0 0 0",
               timed_out, unstable, rdy_during);
    end
    for (int d = 0; d < 3; d++) begin
      logic [15:0] e;
      e = codeword(d, m);
      checks++;
      if ({got[d][3], got[d][2], got[d][1], got[d][0]} !== e) begin
        errors++;
        $display("FAIL bp_words dut%0d got %h%h%h%h exp %h", d,
                 got[d][3], got[d][2], got[d][1], got[d][0], e);
      end
    end
    checks++;
    if (in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_rdy_after got %b exp 1", in_ready[0]);
    end
  endtask

  task automatic test_early_last;
    int e0;
    int seen_ov;
    e0 = ferr_cnt[0];
    send_word(4'h3, 1'b1);
    checks++;
    if (frame_err[0] !== 1'b1 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1
        || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL early_state got fe=%b bz=%b rdy=%b ov=%b exp 1 0 1 0",
               frame_err[0], busy[0], in_ready[0], out_valid[0]);
    end
    seen_ov = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) seen_ov++;
    end
    checks++;
    if (seen_ov != 0 || ferr_cnt[0] - e0 != 1) begin
      errors++;
      $display("FAIL early_idle got bad=%0d pulses=%0d exp 0 1",
               seen_ov, ferr_cnt[0] - e0);
    end
    send_frame(8'hA5, 1, 0);
    collect(0);
    checks++;
    if ({got[0][3], got[0][2], got[0][1], got[0][0]} !== 16'hA5A5) begin
      errors++;
      $display("FAIL early_next got %h%h%h%h exp a5a5",
               got[0][3], got[0][2], got[0][1], got[0][0]);
    end
  endtask

  task automatic test_missing_last;
    int e0;
    e0 = ferr_cnt[0];
    send_frame(8'hA5, 0, 0);
    collect(0);
    checks++;
    if (ferr_cnt[0] - e0 != 1) begin
      errors++;
      $display("FAIL missing_pulse got %0d exp 1", ferr_cnt[0] - e0);
    end
    for (int d = 0; d < 3; d++) begin
      logic [15:0] e;
      e = codeword(d, 8'hA5);
      checks++;
      if (timed_out != 0 || {got[d][3], got[d][2], got[d][1], got[d][0]} !== e) begin
        errors++;
        $display("FAIL missing_words dut%0d got %h%h%h%h exp %h", d,
                 got[d][3], got[d][2], got[d][1], got[d][0], e);
      end
    end
  endtask

  task automatic test_clear_reset;
    int e0;
    int bad;
    send_frame(8'hFF, 1, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checks++;
    if (out_valid[1] !== 1'b0 || busy[1] !== 1'b0 || in_ready[1] !== 1'b1
        || out_data[1] !== 4'h0 || out_last[1] !== 1'b0) begin
      errors++;
      $display("FAIL clr_emit got ov=%b bz=%b rdy=%b od=%h ol=%b exp 0 0 1 0 0",
               out_valid[1], busy[1], in_ready[1], out_data[1], out_last[1]);
    end
    bad = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (out_valid[1] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clr_no_partial got %0d cycles valid exp 0", bad);
    end
    e0 = ferr_cnt[0];
    clr = 1'b1;
    send_word(4'h3, 1'b1);
    clr = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ferr_cnt[0] != e0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL clr_priority got pulses=%0d bz=%b exp 0 0",
               ferr_cnt[0] - e0, busy[0]);
    end
    send_word(4'hF, 1'b0);
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL load_busy got %b exp 1", busy[0]);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (busy[0] !== 1'b0 || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got bz=%b rdy=%b ov=%b exp 0 0 0",
               busy[0], in_ready[0], out_valid[0]);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    send_frame(8'hA5, 1, 0);
    collect(0);
    for (int d = 0; d < 3; d++) begin
      logic [15:0] e;
      e = codeword(d, 8'hA5);
      checks++;
      if (timed_out != 0 || {got[d][3], got[d][2], got[d][1], got[d][0]} !== e) begin
        errors++;
        $display("FAIL post_abort dut%0d got %h%h%h%h exp %h", d,
                 got[d][3], got[d][2], got[d][1], got[d][0], e);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] m;
    int e0;
    e0 = ferr_cnt[2];
    for (int n = 0; n < 25; n++) begin
      m = 8'($urandom);
      send_frame(m, 1, 1);
      collect(2);
      checks++;
      if (timed_out != 0 || unstable != 0 || rdy_during != 0) begin
        errors++;
        $display("FAIL rand_hs frame%0d got timeout=%0d unstable=%0d rdy=%0d exp 0",
                 n, timed_out, unstable, rdy_during);
      end
      for (int d = 0; d < 3; d++) begin
        logic [15:0] e;
        e = codeword(d, m);
        checks++;
        if ({got[d][3], got[d][2], got[d][1], got[d][0]} !== e) begin
          errors++;
          $display("FAIL rand_words frame%0d dut%0d msg=%h got %h%h%h%h exp %h",
                   n, d, m, got[d][3], got[d][2], got[d][1], got[d][0], e);
        end
      end
    end
    checks++;
    if (ferr_cnt[2] != e0) begin
      errors++;
      $display("FAIL rand_ferr got %0d exp 0", ferr_cnt[2] - e0);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_all_ones();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_clear_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sntc_ldpc_encoder_stream.md
# sntc_ldpc_encoder_stream

Streaming, parametrised LDPC systematic encoder for the sntc LDPC datapath. It accepts a KK-bit message as W-bit words over a valid/ready handshake and accumulates the parity on the fly from a generator-parity matrix parameter. It then emits the NN-bit codeword as W-bit words over a second valid/ready handshake. It supersedes the single-shot combinational encoder wrapper by adding word-serial I/O, backpressure, frame checking and synchronous clear, so it can sit directly between a message source and the syndrome checker or channel interface.

## Interface
- KK, 40: message bits per frame; KK % W == 0 required.
- MM, 168: parity bits per frame.
- NN, KK+MM: codeword bits (derived, do not override).
- W, 8: input/output word width; NN % W == 0 required.
- PMAT, all-zero: [KK*MM-1:0] generator-parity matrix. Bit PMAT[j*MM+i] = 1 means message bit j contributes to parity bit i. Must be overridden per code.
- clk  in  1  sole clock; all logic rising-edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- clr  in  1  synchronous clear, active-high.
- in_data  in  W  message word; bit b of word n is message bit n*W+b.
- in_valid  in  1  source has a word.
- in_last  in  1  source marks final message word; qualified by in_valid.
- in_ready  out  1  block accepts a word this cycle.
- out_data  out  W  codeword word; bit b of word n is codeword bit n*W+b.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts out_data.
- out_last  out  1  final codeword word; qualified by out_valid.
- busy  out  1  a frame is partially loaded or being emitted.
- frame_err  out  1  one-cycle pulse on an in_last mismatch.

## Operation
- Codeword layout: y[KK-1:0] = message and y[NN-1:KK] = parity p. Parity is p[i] = XOR over j of (msg[j] & PMAT[j*MM+i]).
- The block has two states, LOAD and EMIT. Both rst and clr enter LOAD with the word counter, message buffer and parity accumulator at 0.
- LOAD:
  - in_ready = 1.
  - On in_valid & in_ready, word n = cnt is stored at msg[n*W +: W].
  - On the same edge, each set bit b XORs PMAT row (cnt*W+b) into the parity accumulator.
  - cnt then increments.
- Transition LOAD to EMIT: when word cnt = KK/W-1 is accepted. On that edge cnt resets to 0 and the final accumulator value is captured.
- EMIT:
  - in_ready = 0 and out_valid = 1.
  - out_data = codeword word cnt. Words 0..KK/W-1 are the message; the remaining words are parity.
  - out_last = 1 when cnt = NN/W-1.
  - Each out_valid & out_ready advances cnt.
  - The handshake on the last word returns the block to LOAD with the accumulator cleared.
- busy = (LOAD and cnt != 0) or EMIT.
- in_last checking:
  - in_last = 1 on an accepted word with cnt < KK/W-1 (early): frame_err pulses, the frame is discarded, and the block stays in LOAD with cnt, buffer and accumulator cleared.
  - in_last = 0 on the final accepted word (missing): frame_err pulses, but the word count governs and the frame is encoded and emitted normally.
- clr has priority over any handshake in the same cycle. That handshake is ignored, and frame_err is not pulsed.
- Reset or clr mid-frame (LOAD or EMIT) aborts the frame. No partial words are output afterwards.

## Timing
- Values during and on release of reset: in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0, frame_err=0. in_ready rises on the first clk edge after rst falls.
- All outputs are registered or decoded from registered state only, with no combinational in-to-out path. out_ready does not gate out_valid.
- Latency: if the final message word is accepted at edge t, out_valid=1 with word 0 is visible after t. With out_ready held high, the last codeword word is handshaken at edge t+NN/W.
- in_ready is 1 again after the edge that handshakes out_last. Minimum frame period is KK/W + NN/W cycles.
- out_data and out_last hold stable while out_valid & !out_ready.
- frame_err is high for exactly the cycle after the offending acceptance edge.
- After clr is asserted at edge t: from t, outputs are at their reset values except in_ready=1.

## Test plan
- Identity code. Stimulus: KK=8, MM=8, W=4, PMAT = identity, input words 0x5 then 0xA (in_last on 0xA), out_ready=1. Response: out_data 0x5, 0xA, 0x5, 0xA on consecutive cycles, out_last on the 4th word, frame_err=0.
- All-ones matrix. Stimulus: same widths, PMAT all-ones, message 0x07 (words 0x7, 0x0). Response: out words 0x7, 0x0, 0xF, 0xF. Repeat with message 0x03: parity words 0x0, 0x0.
- Backpressure. Stimulus: identity code, out_ready toggling 1010 during EMIT. Response: each word is held stable until handshaken, the order is unchanged, and in_ready stays 0 until after out_last is handshaken.
- Early in_last. Stimulus: in_last on word 0 (0x3). Response: frame_err pulses once, there is no output, in_ready stays 1, and the next frame 0x5/0xA encodes correctly.
- Missing in_last. Stimulus: frame 0x5/0xA with in_last=0. Response: frame_err pulses once and the codeword is still 0x5, 0xA, 0x5, 0xA.
- Clear and reset mid-frame. Stimulus: assert clr during EMIT after word 1, then rst during LOAD after one word. Response: out_valid drops the next cycle and busy=0. The following frame 0xA5 emits 0x5, 0xA, 0x5, 0xA with no stale parity.
